// File: rtl/pong_vga_render_pkg.sv
// Shared constants for the pong VGA renderer: 640x480@60 timing, shape sizes,
// fixed screen positions and RGB565 colour codes.
package pong_vga_render_pkg;

  localparam int H_DISP = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_DISP = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int BALL_W = 10;
  localparam int SLDE_W = 10;
  localparam int BODY_W = 5;
  localparam int BODY_L = 60;

  localparam int PAD_L_X    = 55;
  localparam int PAD_R_X    = 580;
  localparam int SCORE_Y    = 16;
  localparam int SCORE_SZ   = 16;
  localparam int SCORE_L_X  = 200;
  localparam int SCORE_R_X  = 392;
  localparam int SCORE_STEP = 24;
  localparam int CENTER_X   = 319;

  localparam logic [15:0] C_BALL   = 16'hFFFF;
  localparam logic [15:0] C_PAD    = 16'h07E0;
  localparam logic [15:0] C_WALL   = 16'h8410;
  localparam logic [15:0] C_SCORE  = 16'hFFE0;
  localparam logic [15:0] C_CENTER = 16'h4208;
  localparam logic [15:0] C_BG     = 16'h0000;
  localparam logic [15:0] C_OVER   = 16'hF800;

  // v in [lo, lo+len-1]; the upper bound is 11 bits wide so lo+len never wraps
  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [10:0] len);
    return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} < ({1'b0, lo} + len));
  endfunction

endpackage

// File: rtl/pong_vga_render_vga_timing.sv
// Raster counters and raw (unpipelined) sync / display-enable / frame-end.
module vga_timing #(
  parameter int HDISP = 640, parameter int HFP = 16, parameter int HSYNC = 96, parameter int HBP = 48,
  parameter int VDISP = 480, parameter int VFP = 10, parameter int VSYNC = 2,  parameter int VBP = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic       frame_end
);
  localparam int H_TOT = HDISP + HFP + HSYNC + HBP;
  localparam int V_TOT = VDISP + VFP + VSYNC + VBP;

  logic h_last, v_last;
  assign h_last = (h_cnt == 10'(H_TOT - 1));
  assign v_last = (v_cnt == 10'(V_TOT - 1));

  // h wraps every line; v advances on each h wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign hs = !((h_cnt >= 10'(HDISP + HFP)) && (h_cnt < 10'(HDISP + HFP + HSYNC)));
  assign vs = !((v_cnt >= 10'(VDISP + VFP)) && (v_cnt < 10'(VDISP + VFP + VSYNC)));
  assign de = (h_cnt < 10'(HDISP)) && (v_cnt < 10'(VDISP));
  assign frame_end = h_last && v_last;

endmodule

// File: rtl/pong_vga_render.sv
// Pong renderer: frame-shadowed game state, shape hit tests and a 2-stage
// output pipeline aligned with the sync signals.
module pong_vga_render
  import pong_vga_render_pkg::*;
#(
  parameter int HDISP = H_DISP, parameter int HFP = H_FP, parameter int HSYNC = H_SYNC, parameter int HBP = H_BP,
  parameter int VDISP = V_DISP, parameter int VFP = V_FP, parameter int VSYNC = V_SYNC, parameter int VBP = V_BP
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [9:0]  body_x,
  input  logic [9:0]  body_y,
  input  logic [9:0]  padbody_y0,
  input  logic [9:0]  padbody_y1,
  input  logic [3:0]  score,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        frame_tick
);
  logic [9:0] x, y;
  logic       hs0, vs0, de0, frame_end;

  vga_timing #(
    .HDISP(HDISP), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP)
  ) u_timing (
    .clk(vga_clk), .rst(sys_rst), .h_cnt(x), .v_cnt(y),
    .hs(hs0), .vs(vs0), .de(de0), .frame_end(frame_end)
  );

  assign frame_tick = frame_end;

  logic [9:0] sh_bx, sh_by, sh_py0, sh_py1;
  logic [3:0] sh_score;
  logic       sh_start;

  // game state is captured once per frame so the picture never tears
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      sh_bx    <= 10'd315;
      sh_by    <= 10'd235;
      sh_py0   <= 10'd210;
      sh_py1   <= 10'd210;
      sh_score <= 4'd0;
      sh_start <= 1'b0;
    end else if (frame_end) begin
      sh_bx    <= body_x;
      sh_by    <= body_y;
      sh_py0   <= padbody_y0;
      sh_py1   <= padbody_y1;
      sh_score <= score;
      sh_start <= start;
    end
  end

  logic ball_c, pad_c, wall_c, score_c, center_c, over_c;

  assign ball_c = sh_start && in_range(x, sh_bx, 11'(BALL_W)) && in_range(y, sh_by, 11'(BALL_W));
  assign pad_c  = (in_range(x, 10'(PAD_L_X), 11'(BODY_W)) && in_range(y, sh_py0, 11'(BODY_L)))
               || (in_range(x, 10'(PAD_R_X), 11'(BODY_W)) && in_range(y, sh_py1, 11'(BODY_L)));
  assign wall_c = (x < 10'(SLDE_W)) || (x >= 10'(HDISP - SLDE_W))
               || (y < 10'(SLDE_W)) || (y >= 10'(VDISP - SLDE_W));
  assign center_c = ((x == 10'(CENTER_X)) || (x == 10'(CENTER_X + 1))) && !y[4];
  assign over_c   = (sh_score[1:0] == 2'd3) || (sh_score[3:2] == 2'd3);

  // up to three tally blocks per side; block i is lit while i < that side's tally
  always_comb begin
    score_c = 1'b0;
    if (in_range(y, 10'(SCORE_Y), 11'(SCORE_SZ))) begin
      for (int i = 0; i < 3; i++) begin
        if (i < int'(sh_score[1:0]) && in_range(x, 10'(SCORE_L_X + SCORE_STEP * i), 11'(SCORE_SZ)))
          score_c = 1'b1;
        if (i < int'(sh_score[3:2]) && in_range(x, 10'(SCORE_R_X + SCORE_STEP * i), 11'(SCORE_SZ)))
          score_c = 1'b1;
      end
    end
  end

  logic ball1, pad1, wall1, score1, center1, over1, de1, hs1, vs1;

  // stage 1: register hits together with the raw timing signals
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      {ball1, pad1, wall1, score1, center1, over1, de1} <= '0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
    end else begin
      ball1   <= ball_c;
      pad1    <= pad_c;
      wall1   <= wall_c;
      score1  <= score_c;
      center1 <= center_c;
      over1   <= over_c;
      de1     <= de0;
      hs1     <= hs0;
      vs1     <= vs0;
    end
  end

  logic [15:0] color;

  // fixed colour priority, game-over tints the background
  always_comb begin
    color = over1 ? C_OVER : C_BG;
    if (ball1)        color = C_BALL;
    else if (pad1)    color = C_PAD;
    else if (wall1)   color = C_WALL;
    else if (score1)  color = C_SCORE;
    else if (center1) color = C_CENTER;
  end

  // stage 2: blank outside the visible area
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      vga_rgb <= '0;
      vga_de  <= 1'b0;
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
    end else begin
      vga_rgb <= de1 ? color : 16'h0000;
      vga_de  <= de1;
      vga_hs  <= hs1;
      vga_vs  <= vs1;
    end
  end

endmodule

// File: tb/tb_pong_vga_render.sv
// Directed bench for pong_vga_render, run with short porches and a 36-line
// display so that several whole frames fit in a short run.
module tb_pong_vga_render;
  localparam int HD = 640, HF = 4, HS = 8, HB = 4;
  localparam int VD = 36,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;   // 656
  localparam int VT = VD + VF + VS + VB;   // 40

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  body_x = '0, body_y = '0, padbody_y0 = '0, padbody_y1 = '0;
  logic [3:0]  score = '0;
  logic        vga_hs, vga_vs, vga_de, frame_tick;
  logic [15:0] vga_rgb;

  pong_vga_render #(
    .HDISP(HD), .HFP(HF), .HSYNC(HS), .HBP(HB),
    .VDISP(VD), .VFP(VF), .VSYNC(VS), .VBP(VB)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .start(start),
    .body_x(body_x), .body_y(body_y), .padbody_y0(padbody_y0), .padbody_y1(padbody_y1),
    .score(score), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_rgb(vga_rgb), .frame_tick(frame_tick)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge vga_clk);
  endtask

  // pixel (x,y) of a frame whose first counter cycle is base leaves stage 2 at base+2+n
  task automatic px(input string tag, input int base, input int x, input int y, input logic [15:0] exp);
    wait_cyc(base + 2 + y * HT + x);
    chk(tag, vga_rgb, exp);
  endtask

  // waits at negedges until sig matches val; a timeout counts as a failed check
  task automatic wait_sig(input string tag, input int which, input logic val, input int limit);
    int n;
    logic s;
    n = 0;
    forever begin
      case (which)
        0: s = vga_hs;
        1: s = vga_vs;
        default: s = frame_tick;
      endcase
      if (s == val || n >= limit) break;
      @(negedge vga_clk);
      n++;
    end
    if (n >= limit) chk({tag, "_timeout"}, 32'(s), 32'(val));
  endtask

  int e, t, base1, base2, tick1;

  initial begin
    repeat (3) @(negedge vga_clk);
    chk("rst_hs", vga_hs, 1);
    chk("rst_vs", vga_vs, 1);
    chk("rst_de", vga_de, 0);
    chk("rst_rgb", vga_rgb, 16'h0000);
    chk("rst_tick", frame_tick, 0);

    sys_rst = 1'b0;
    e = cyc;
    wait_sig("hs_fall", 0, 1'b0, 2000);
    chk("hs_first_fall", cyc - e, HD + HF + 2);
    t = cyc;
    wait_sig("hs_rise", 0, 1'b1, 2000);
    chk("hs_width", cyc - t, HS);
    wait_sig("hs_fall2", 0, 1'b0, 2000);
    chk("hs_period", cyc - t, HT);

    // frame 0 is drawn from the reset shadow values
    px("f0_center", e, 319, 12, 16'h4208);
    px("f0_wall", e, 5, 15, 16'h8410);
    px("f0_bg", e, 105, 15, 16'h0000);
    chk("f0_de_in", vga_de, 1);
    px("f0_hblank", e, 645, 15, 16'h0000);
    chk("f0_de_out", vga_de, 0);
    px("f0_gap", e, 320, 16, 16'h0000);

    start = 1'b1; body_x = 10'd100; body_y = 10'd12;
    padbody_y0 = 10'd5; padbody_y1 = 10'd5; score = 4'b0110;

    wait_sig("vs_fall", 1, 1'b0, HT * VT);
    chk("vs_fall_at", cyc - e, (VD + VF) * HT + 2);
    t = cyc;
    wait_sig("vs_rise", 1, 1'b1, HT * VT);
    chk("vs_width", cyc - t, VS * HT);

    wait_sig("tick1", 2, 1'b1, HT * VT + 10);
    tick1 = cyc;
    base1 = cyc + 1;
    px("f1_lpad_over_wall", base1, 57, 5, 16'h07E0);
    px("f1_rpad", base1, 582, 8, 16'h07E0);
    px("f1_ball", base1, 105, 14, 16'hFFFF);
    px("f1_past_ball", base1, 110, 14, 16'h0000);
    body_x = 10'd300; score = 4'b1100;
    px("f1_ball_held", base1, 105, 18, 16'hFFFF);
    px("f1_no_new_ball", base1, 300, 18, 16'h0000);
    px("f1_score_l0", base1, 205, 20, 16'hFFE0);
    px("f1_score_l1", base1, 229, 20, 16'hFFE0);
    px("f1_score_l2", base1, 253, 20, 16'h0000);
    px("f1_score_r0", base1, 397, 20, 16'hFFE0);
    px("f1_score_r1", base1, 421, 20, 16'h0000);
    px("f1_wall_right", base1, 635, 20, 16'h8410);
    px("f1_wall_bottom", base1, 300, 30, 16'h8410);

    wait_sig("tick2", 2, 1'b1, HT * VT + 10);
    chk("frame_period", cyc - tick1, HT * VT);
    base2 = cyc + 1;
    px("f2_over_bg", base2, 105, 14, 16'hF800);
    px("f2_ball_moved", base2, 305, 14, 16'hFFFF);
    px("f2_score_l_off", base2, 205, 20, 16'hF800);
    px("f2_score_r2", base2, 445, 20, 16'hFFE0);

    // one-cycle reset in the middle of a wall-coloured line
    wait_cyc(base2 + 30 * HT + 400);
    sys_rst = 1'b1;
    @(negedge vga_clk);
    chk("mid_rst_hs", vga_hs, 1);
    chk("mid_rst_vs", vga_vs, 1);
    chk("mid_rst_de", vga_de, 0);
    chk("mid_rst_rgb", vga_rgb, 16'h0000);
    sys_rst = 1'b0;
    e = cyc;
    wait_sig("hs_fall3", 0, 1'b0, 2000);
    chk("mid_rst_hs_fall", cyc - e, HD + HF + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
